// File: rtl/inv_sub_bytes_unit.sv
// inv_sub_bytes_unit: iterative AES InvSubBytes engine, LANES bytes substituted per cycle in place.
module inv_sub_bytes_unit #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int ITER = 16 / LANES;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  data_q, data_d;
  logic          last;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ p : r;
      p = xtime(p);
    end
    return r;
  endfunction

  // inverse affine map, then x^254 which is the GF(2^8) inverse and sends 0 to 0
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y, p, r;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last    = cnt_q == CW'(ITER - 1);
    case (state_q)
      IDLE: begin
        data_d  = in_valid ? data_in : data_q;
        cnt_d   = in_valid ? '0 : cnt_q;
        state_d = in_valid ? BUSY : IDLE;
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++)
          data_d[127-8*(LANES*int'(cnt_q)+l) -: 8] = inv_sbox(data_q[127-8*(LANES*int'(cnt_q)+l) -: 8]);
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : BUSY;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == BUSY;
  assign data_out  = out_valid ? data_q : '0;
endmodule

// File: tb/tb_inv_sub_bytes_unit.sv
// tb_inv_sub_bytes_unit: randomized self-checking bench against a table model of the inverse S-box.
module tb_inv_sub_bytes_unit;
  logic         clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [127:0] data_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] data_out;
  logic [3:0]   g_ir, g_ov, g_bz;
  logic [127:0] g_do [4];
  int           total = 0, bad = 0;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  localparam logic [127:0] VEC = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] VEC_EXP = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  inv_sub_bytes_unit #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : gl
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_sub_bytes_unit #(.LANES(L)) u (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(g_ir[g]), .data_in(data_in),
      .out_valid(g_ov[g]), .out_ready(out_ready), .data_out(g_do[g]), .busy(g_bz[g])
    );
  end

  function automatic int gm(input int a, input int b);
    int r = 0;
    for (int i = 0; i < 8; i++) begin
      if (b & 1) r ^= a;
      a = a << 1;
      if (a & 256) a ^= 'h11b;
      b = b >> 1;
    end
    return r;
  endfunction

  // forward S-box by brute-force inversion plus the textbook affine map, then inverted as a table
  task automatic build_model;
    int inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(x, y) == 1) inv = y;
      s = inv;
      for (int k = 1; k < 5; k++) s ^= ((inv << k) | (inv >> (8 - k))) & 255;
      s ^= 'h63;
      sb[x] = s[7:0];
      isb[s[7:0]] = x[7:0];
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [127:0] din, output logic [127:0] dout, output int lat);
    out_ready = 1;
    data_in = din;
    in_valid = 1;
    lat = 0;
    while (!in_ready && lat < 40) begin tick; lat++; end
    tick;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin tick; lat++; end
    dout = data_out;
    tick;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) tick;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
    reset = 1;
    tick;
  endtask

  task automatic test_lanes;
    int lat [5];
    logic [127:0] dat [5];
    int lv [5] = '{1, 2, 8, 16, 4};
    int c;
    for (int g = 0; g < 5; g++) begin lat[g] = 0; dat[g] = '0; end
    data_in = VEC;
    in_valid = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    c = 1;
    repeat (21) begin
      for (int g = 0; g < 4; g++)
        if (g_ov[g] && lat[g] == 0) begin lat[g] = c; dat[g] = g_do[g]; end
      if (out_valid && lat[4] == 0) begin lat[4] = c; dat[4] = data_out; end
      tick;
      c++;
    end
    for (int g = 0; g < 5; g++) begin
      total += 2;
      if (lat[g] != 16 / lv[g] + 1) begin bad++; $display("FAIL lanes%0d_latency got=%0d want=%0d", lv[g], lat[g], 16 / lv[g] + 1); end
      if (dat[g] !== VEC_EXP) begin bad++; $display("FAIL lanes%0d_data got=%h want=%h", lv[g], dat[g], VEC_EXP); end
    end
  endtask

  task automatic test_zero;
    int lat;
    data_in = {16{8'h63}};
    in_valid = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    total += 3;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL accept_in_ready got=%b want=0", in_ready); end
    if (busy !== 1'b1) begin bad++; $display("FAIL accept_busy got=%b want=1", busy); end
    lat = 1;
    while (!out_valid && lat < 40) begin tick; lat++; end
    if (lat != 5) begin bad++; $display("FAIL zero_latency got=%0d want=5", lat); end
    total++;
    if (data_out !== '0) begin bad++; $display("FAIL zero_data got=%h want=0", data_out); end
    tick;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 0;
    data_in = {16{8'h16}};
    in_valid = 1;
    tick;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin tick; lat++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
      if (data_out !== {16{8'hff}}) begin bad++; $display("FAIL bp_data cyc=%0d got=%h want=%h", i, data_out, {16{8'hff}}); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      tick;
    end
    in_valid = 0;
    out_ready = 1;
    tick;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    tick;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept busy got=%b want=0", busy); end
  endtask

  task automatic test_exhaustive;
    logic [127:0] din, exp_d, dout;
    int lat;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        din[127-8*j -: 8] = sb[16*k+j];
        exp_d[127-8*j -: 8] = 8'(16*k+j);
      end
      run_one(din, dout, lat);
      total++;
      if (dout !== exp_d) begin bad++; $display("FAIL exhaustive_blk%0d got=%h want=%h", k, dout, exp_d); end
    end
    din = 128'h0052ed7c63160109_53ff48aa5500c3e1;
    run_one(din, dout, lat);
    total += 2;
    if (dout !== model(din)) begin bad++; $display("FAIL spot_model got=%h want=%h", dout, model(din)); end
    if (dout[127:72] !== 56'h52485301_00ff09) begin bad++; $display("FAIL spot_const got=%h want=52485301_00ff09", dout[127:72]); end
    run_one(VEC, dout, lat);
    total += 2;
    if (dout !== VEC_EXP) begin bad++; $display("FAIL vector_data got=%h want=%h", dout, VEC_EXP); end
    if (lat != 5) begin bad++; $display("FAIL vector_latency got=%0d want=5", lat); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] dout;
    int lat, seen;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    tick;
    tick;
    reset = 0;
    #1;
    for (int r = 0; r < 2; r++) begin
      total += 4;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready ph=%0d got=%b want=1", r, in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid ph=%0d got=%b want=0", r, out_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy ph=%0d got=%b want=0", r, busy); end
      if (data_out !== '0) begin bad++; $display("FAIL midrst_data ph=%0d got=%h want=0", r, data_out); end
      if (r == 0) tick;
    end
    reset = 1;
    seen = 0;
    repeat (10) begin tick; if (out_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
    run_one({16{8'h63}}, dout, lat);
    total += 2;
    if (dout !== '0) begin bad++; $display("FAIL midrst_after_data got=%h want=0", dout); end
    if (lat != 5) begin bad++; $display("FAIL midrst_after_latency got=%0d want=5", lat); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] q [$];
    int sent = 0, recv = 0, cyc = 0, extra = 0;
    bit fired = 0;
    in_valid = 0;
    while (recv < 20 && cyc < 3000) begin
      if (fired) in_valid = 0;
      fired = 0;
      if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        data_in = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1;
      end
      if (in_valid && in_ready) begin q.push_back(model(data_in)); sent++; fired = 1; end
      out_ready = $urandom_range(0, 1) == 1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0 || data_out !== q[0])
          begin bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", recv, data_out, q.size() ? q[0] : 'x); end
        if (q.size() != 0) void'(q.pop_front());
        recv++;
      end
      tick;
      cyc++;
    end
    if (fired) in_valid = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (10) begin tick; if (out_valid) extra++; end
    total += 3;
    if (recv != 20) begin bad++; $display("FAIL b2b_count got=%0d want=20", recv); end
    if (q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", q.size()); end
    if (extra != 0) begin bad++; $display("FAIL b2b_duplicate got=%0d want=0", extra); end
  endtask

  initial begin
    build_model;
    test_reset;
    test_lanes;
    test_zero;
    test_backpressure;
    test_exhaustive;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
